// File: rtl/mor1kx_wb_stage_cappuccino.sv
// Writeback stage of the cappuccino pipeline.
// Registers the ctrl-stage result into the writeback stage, aligns and
// extends load data, and parks load data that arrives before the pipeline
// advances in a one-entry hold buffer (IDLE/HOLD FSM).
//
// Handshake: lsu_valid_i is a one-cycle pulse qualifying lsu_dat_i for the
// load currently in ctrl; padv_wb_i is the advance strobe that transfers the
// ctrl instruction into writeback on that edge. pipeline_flush_i kills the
// transfer and any held load data. A load advanced in IDLE without
// lsu_valid_i is an upstream protocol error and produces no GPR write.
// The FSM state is exposed directly on wb_load_held_o.
//
// Load byte lanes are big-endian within the low 32 bits of the operand.
module mor1kx_wb_stage_cappuccino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_wb_i,
    input  logic                            pipeline_flush_i,
    input  logic                            ctrl_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
    input  logic                            ctrl_op_lsu_load_i,
    input  logic [1:0]                      ctrl_lsu_length_i,
    input  logic                            ctrl_lsu_zext_i,
    input  logic [1:0]                      ctrl_lsu_adr_i,
    input  logic                            lsu_valid_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_dat_i,
    input  logic                            ctrl_op_mfspr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_dat_i,
    input  logic                            ctrl_op_mul_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] mul_result_i,
    output logic                            wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
    output logic                            wb_load_held_o
);

    localparam int W = OPTION_OPERAND_WIDTH;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]   state;
    logic [W-1:0] hold_q;
    logic [W-1:0] load_aligned;
    logic [W-1:0] load_dat;
    logic [W-1:0] sel_result;
    logic [7:0]   lane_byte;
    logic [15:0]  lane_half;
    logic         capture;
    logic         load_missing;

    // Pick the addressed byte/half lane (big-endian) and extend it.
    always_comb begin
        lane_byte = 8'h00;
        lane_half = 16'h0000;
        case (ctrl_lsu_adr_i)
            2'd0:    lane_byte = lsu_dat_i[31:24];
            2'd1:    lane_byte = lsu_dat_i[23:16];
            2'd2:    lane_byte = lsu_dat_i[15:8];
            default: lane_byte = lsu_dat_i[7:0];
        endcase
        lane_half = ctrl_lsu_adr_i[1] ? lsu_dat_i[15:0] : lsu_dat_i[31:16];

        case (ctrl_lsu_length_i)
            2'b00:   load_aligned = {{(W-8){lane_byte[7] & ~ctrl_lsu_zext_i}}, lane_byte};
            2'b01:   load_aligned = {{(W-16){lane_half[15] & ~ctrl_lsu_zext_i}}, lane_half};
            default: load_aligned = lsu_dat_i;
        endcase
    end

    // Result mux: load > mfspr > mul > ALU; held load data wins over live bus.
    always_comb begin
        load_dat = (state == HOLD) ? hold_q : load_aligned;
        if (ctrl_op_lsu_load_i)
            sel_result = load_dat;
        else if (ctrl_op_mfspr_i)
            sel_result = spr_dat_i;
        else if (ctrl_op_mul_i)
            sel_result = mul_result_i;
        else
            sel_result = ctrl_alu_result_i;
    end

    assign capture      = (state == IDLE) & ctrl_op_lsu_load_i & lsu_valid_i &
                          ~padv_wb_i & ~pipeline_flush_i;
    assign load_missing = (state == IDLE) & ctrl_op_lsu_load_i & ~lsu_valid_i;

    // FSM and writeback registers; flush beats advance, reset beats both.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wb_rf_wb_o   <= 1'b0;
            wb_rfd_adr_o <= '0;
            result_o     <= '0;
        end else begin
            wb_rf_wb_o <= 1'b0;
            if (pipeline_flush_i) begin
                state <= IDLE;
            end else if (padv_wb_i) begin
                state        <= IDLE;
                wb_rfd_adr_o <= ctrl_rfd_adr_i;
                result_o     <= sel_result;
                wb_rf_wb_o   <= ctrl_rf_wb_i & ~load_missing;
            end else if (capture) begin
                state <= HOLD;
            end
        end
    end

    // Hold buffer needs no reset: it is only read while the FSM is in HOLD.
    always_ff @(posedge clk) begin
        if (capture)
            hold_q <= load_aligned;
    end

    assign wb_load_held_o = (state == HOLD);

endmodule

// File: tb/tb_mor1kx_wb_stage_cappuccino.sv
// Directed bench for mor1kx_wb_stage_cappuccino.
module tb_mor1kx_wb_stage_cappuccino;

    logic        clk;
    logic        rst;
    logic        padv_wb_i;
    logic        pipeline_flush_i;
    logic        ctrl_rf_wb_i;
    logic [4:0]  ctrl_rfd_adr_i;
    logic [31:0] ctrl_alu_result_i;
    logic        ctrl_op_lsu_load_i;
    logic [1:0]  ctrl_lsu_length_i;
    logic        ctrl_lsu_zext_i;
    logic [1:0]  ctrl_lsu_adr_i;
    logic        lsu_valid_i;
    logic [31:0] lsu_dat_i;
    logic        ctrl_op_mfspr_i;
    logic [31:0] spr_dat_i;
    logic        ctrl_op_mul_i;
    logic [31:0] mul_result_i;
    logic        wb_rf_wb_o;
    logic [4:0]  wb_rfd_adr_o;
    logic [31:0] result_o;
    logic        wb_load_held_o;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    mor1kx_wb_stage_cappuccino dut (
        .clk                (clk),
        .rst                (rst),
        .padv_wb_i          (padv_wb_i),
        .pipeline_flush_i   (pipeline_flush_i),
        .ctrl_rf_wb_i       (ctrl_rf_wb_i),
        .ctrl_rfd_adr_i     (ctrl_rfd_adr_i),
        .ctrl_alu_result_i  (ctrl_alu_result_i),
        .ctrl_op_lsu_load_i (ctrl_op_lsu_load_i),
        .ctrl_lsu_length_i  (ctrl_lsu_length_i),
        .ctrl_lsu_zext_i    (ctrl_lsu_zext_i),
        .ctrl_lsu_adr_i     (ctrl_lsu_adr_i),
        .lsu_valid_i        (lsu_valid_i),
        .lsu_dat_i          (lsu_dat_i),
        .ctrl_op_mfspr_i    (ctrl_op_mfspr_i),
        .spr_dat_i          (spr_dat_i),
        .ctrl_op_mul_i      (ctrl_op_mul_i),
        .mul_result_i       (mul_result_i),
        .wb_rf_wb_o         (wb_rf_wb_o),
        .wb_rfd_adr_o       (wb_rfd_adr_o),
        .result_o           (result_o),
        .wb_load_held_o     (wb_load_held_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        padv_wb_i          = 1'b0;
        pipeline_flush_i   = 1'b0;
        ctrl_rf_wb_i       = 1'b0;
        ctrl_rfd_adr_i     = 5'd0;
        ctrl_alu_result_i  = 32'h0;
        ctrl_op_lsu_load_i = 1'b0;
        ctrl_lsu_length_i  = 2'b10;
        ctrl_lsu_zext_i    = 1'b0;
        ctrl_lsu_adr_i     = 2'd0;
        lsu_valid_i        = 1'b0;
        lsu_dat_i          = 32'h0;
        ctrl_op_mfspr_i    = 1'b0;
        spr_dat_i          = 32'h0;
        ctrl_op_mul_i      = 1'b0;
        mul_result_i       = 32'h0;
    endtask

    // Advance with a writing instruction already set up; check the strobe,
    // address and the queued expected result one cycle later.
    task automatic wb_cycle(input string tag, input logic [4:0] adr, input logic [31:0] exp);
        exp_q.push_back(exp);
        padv_wb_i    = 1'b1;
        ctrl_rf_wb_i = 1'b1;
        ctrl_rfd_adr_i = adr;
        step();
        idle_inputs();
        check({tag, "_we"}, wb_rf_wb_o, 1'b1);
        check({tag, "_adr"}, wb_rfd_adr_o, adr);
        check({tag, "_res"}, result_o, exp_q.pop_front());
    endtask

    typedef struct {
        logic [1:0]  len;
        logic        zext;
        logic [1:0]  adr;
        logic [31:0] dat;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t lv[7];

    initial begin
        lv[0] = '{2'b00, 1'b0, 2'd2, 32'h00AA8000, 32'hFFFFFF80};
        lv[1] = '{2'b00, 1'b1, 2'd0, 32'hA1B2C3D4, 32'h000000A1};
        lv[2] = '{2'b00, 1'b0, 2'd3, 32'hA1B2C3D4, 32'hFFFFFFD4};
        lv[3] = '{2'b00, 1'b0, 2'd1, 32'h007F0000, 32'h0000007F};
        lv[4] = '{2'b01, 1'b0, 2'd2, 32'h12348001, 32'hFFFF8001};
        lv[5] = '{2'b01, 1'b0, 2'd0, 32'h70011234, 32'h00007001};
        lv[6] = '{2'b10, 1'b0, 2'd1, 32'hDEADBEEF, 32'hDEADBEEF};

        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_we", wb_rf_wb_o, 1'b0);
        check("rst_adr", wb_rfd_adr_o, 5'd0);
        check("rst_res", result_o, 32'h0);
        check("rst_held", wb_load_held_o, 1'b0);

        // ALU writeback, then strobe drops and values hold
        ctrl_alu_result_i = 32'h12345678;
        wb_cycle("alu", 5'd3, 32'h12345678);
        step();
        check("alu_pulse", wb_rf_wb_o, 1'b0);
        check("alu_hold_res", result_o, 32'h12345678);
        check("alu_hold_adr", wb_rfd_adr_o, 5'd3);

        // Back-to-back advances keep the strobe high
        ctrl_alu_result_i = 32'h0000_0001;
        wb_cycle("b2b0", 5'd1, 32'h0000_0001);
        ctrl_alu_result_i = 32'h0000_0002;
        wb_cycle("b2b1", 5'd2, 32'h0000_0002);

        // Loads with data valid on the advance cycle
        for (int i = 0; i < 7; i++) begin
            ctrl_op_lsu_load_i = 1'b1;
            ctrl_lsu_length_i  = lv[i].len;
            ctrl_lsu_zext_i    = lv[i].zext;
            ctrl_lsu_adr_i     = lv[i].adr;
            lsu_dat_i          = lv[i].dat;
            lsu_valid_i        = 1'b1;
            ctrl_alu_result_i  = 32'h5A5A5A5A;
            wb_cycle($sformatf("ld%0d", i), 5'd5, lv[i].exp);
            check($sformatf("ld%0d_held", i), wb_load_held_o, 1'b0);
        end

        // Result priority
        ctrl_op_mfspr_i = 1'b1; spr_dat_i = 32'h11;
        ctrl_op_mul_i = 1'b1; mul_result_i = 32'h22; ctrl_alu_result_i = 32'h33;
        wb_cycle("spr_over_mul", 5'd9, 32'h11);
        ctrl_op_mul_i = 1'b1; mul_result_i = 32'h22; ctrl_alu_result_i = 32'h33;
        wb_cycle("mul_over_alu", 5'd10, 32'h22);
        ctrl_op_lsu_load_i = 1'b1; lsu_valid_i = 1'b1; lsu_dat_i = 32'h44444444;
        ctrl_op_mfspr_i = 1'b1; spr_dat_i = 32'h11;
        wb_cycle("ld_over_spr", 5'd11, 32'h44444444);

        // Load data arrives three cycles before the advance
        ctrl_op_lsu_load_i = 1'b1;
        ctrl_lsu_length_i  = 2'b01;
        ctrl_lsu_zext_i    = 1'b1;
        ctrl_lsu_adr_i     = 2'd0;
        lsu_dat_i          = 32'h9ABC1234;
        lsu_valid_i        = 1'b1;
        step();
        lsu_valid_i = 1'b0;
        lsu_dat_i   = 32'hFFFFFFFF;
        check("hold_c1", wb_load_held_o, 1'b1);
        check("hold_c1_we", wb_rf_wb_o, 1'b0);
        step();
        lsu_valid_i = 1'b1;
        lsu_dat_i   = 32'h55555555;
        check("hold_c2", wb_load_held_o, 1'b1);
        step();
        lsu_valid_i = 1'b0;
        check("hold_c3", wb_load_held_o, 1'b1);
        check("hold_c3_res", result_o, 32'h44444444);
        wb_cycle("held_ld", 5'd7, 32'h00009ABC);
        check("held_ld_idle", wb_load_held_o, 1'b0);

        // Flush and advance together while holding
        ctrl_op_lsu_load_i = 1'b1; ctrl_lsu_length_i = 2'b10;
        lsu_dat_i = 32'hCAFEF00D; lsu_valid_i = 1'b1;
        step();
        lsu_valid_i = 1'b0;
        check("flush_pre_held", wb_load_held_o, 1'b1);
        pipeline_flush_i = 1'b1; padv_wb_i = 1'b1; ctrl_rf_wb_i = 1'b1; ctrl_rfd_adr_i = 5'd12;
        step();
        idle_inputs();
        check("flush_we", wb_rf_wb_o, 1'b0);
        check("flush_held", wb_load_held_o, 1'b0);
        check("flush_res", result_o, 32'h00009ABC);
        check("flush_adr", wb_rfd_adr_o, 5'd7);

        // Advancing a load in IDLE without valid data must not write
        ctrl_op_lsu_load_i = 1'b1; padv_wb_i = 1'b1; ctrl_rf_wb_i = 1'b1;
        ctrl_rfd_adr_i = 5'd13;
        step();
        idle_inputs();
        check("noval_we", wb_rf_wb_o, 1'b0);
        check("noval_held", wb_load_held_o, 1'b0);

        // Reset in the middle of HOLD discards the held load
        ctrl_alu_result_i = 32'h77;
        wb_cycle("pre_rst", 5'd14, 32'h77);
        ctrl_op_lsu_load_i = 1'b1; lsu_dat_i = 32'hBEEFBEEF; lsu_valid_i = 1'b1;
        step();
        lsu_valid_i = 1'b0;
        check("rst_pre_held", wb_load_held_o, 1'b1);
        rst = 1'b1; padv_wb_i = 1'b1; ctrl_rf_wb_i = 1'b1; ctrl_rfd_adr_i = 5'd15;
        step();
        rst = 1'b0;
        idle_inputs();
        check("midrst_we", wb_rf_wb_o, 1'b0);
        check("midrst_adr", wb_rfd_adr_o, 5'd0);
        check("midrst_res", result_o, 32'h0);
        check("midrst_held", wb_load_held_o, 1'b0);
        step();
        check("midrst_after_we", wb_rf_wb_o, 1'b0);

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
